inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU fetch stage and the backing instruction memory.
- CPU side: the fetch stage presents the PC each cycle. On a hit, the instruction returns combinationally in the same cycle, so IF timing is unchanged.
- On a miss, `stall` is asserted and a multi-beat line refill runs from backing memory over a req/ready + rvalid handshake.
- `flush` invalidates the whole cache, for self-modifying-code tests.

---
 rtl/inst_cache.sv | 164 ++++++++++++++++
 tb/tb_inst_cache.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with single-cycle hit and multi-beat line refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module inst_cache #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned MEM_ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [MEM_ADDR_W-1:0] inst_addr,
    input  logic                  flush,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  stall,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = MEM_ADDR_W - IDX_W - OFF_W - 2;
    localparam int unsigned LOW_W = OFF_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [MEM_ADDR_W-1:0]   r_line_addr;
    logic [OFF_W-1:0]        r_beat;
    logic                    r_kill;
    logic [NUM_LINES-1:0]    r_valid;
    logic [TAG_W-1:0]        r_tag  [NUM_LINES];
    logic [31:0]             r_data [NUM_LINES*WORDS_PER_LINE];

    logic [IDX_W-1:0]        w_idx;
    logic [OFF_W-1:0]        w_off;
    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_fill_idx;
    logic [TAG_W-1:0]        w_fill_tag;
    logic                    w_match;
    logic                    w_hit;
    logic                    w_miss;
    logic                    w_beat_we;
    logic                    w_fill_last;
    logic [1:0]              w_unused;

    assign w_idx       = inst_addr[LOW_W +: IDX_W];
    assign w_off       = inst_addr[2 +: OFF_W];
    assign w_tag       = inst_addr[MEM_ADDR_W-1 -: TAG_W];
    assign w_fill_idx  = r_line_addr[LOW_W +: IDX_W];
    assign w_fill_tag  = r_line_addr[MEM_ADDR_W-1 -: TAG_W];
    assign w_unused    = inst_addr[1:0];

    assign w_match     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit       = !rst && inst_req && (r_state == IDLE) && w_match && !flush;
    assign w_miss      = !rst && inst_req && (r_state == IDLE) && !w_match && !flush;
    assign w_beat_we   = !rst && (r_state == FILL) && mem_rvalid;
    assign w_fill_last = w_beat_we && (r_beat == OFF_W'(WORDS_PER_LINE - 1));

    // Next state and CPU/memory-facing outputs
    always_comb begin
        w_state_nxt = r_state;
        inst        = 32'h0;
        inst_valid  = 1'b0;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (r_state)
            IDLE: if (w_miss) w_state_nxt = REQ;
            REQ:  if (mem_ready) w_state_nxt = FILL;
            FILL: if (w_fill_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_hit) begin
            inst       = r_data[{w_idx, w_off}];
            inst_valid = 1'b1;
        end
        if (!rst) begin
            stall = (r_state != IDLE) || (inst_req && !w_hit);
            if (r_state == REQ) begin
                mem_req  = 1'b1;
                mem_addr = r_line_addr;
            end
        end
    end

    // Control state; a flush mid-refill kills the in-progress line instead of aborting it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_line_addr <= '0;
            r_beat      <= '0;
            r_kill      <= 1'b0;
            r_valid     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_line_addr <= {inst_addr[MEM_ADDR_W-1:LOW_W], LOW_W'(0)};
                r_beat      <= '0;
            end
            if (w_beat_we) begin
                r_beat <= r_beat + OFF_W'(1);
            end
            if (r_state == IDLE) begin
                r_kill <= 1'b0;
            end else if (flush) begin
                r_kill <= 1'b1;
            end
            if (flush) begin
                r_valid <= '0;
            end
            if (w_fill_last && !r_kill && !flush) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; the valid bits guard them
    always_ff @(posedge clk) begin
        if (w_beat_we) begin
            r_data[{w_fill_idx, r_beat}] <= mem_rdata;
        end
        if (w_fill_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'h1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'h1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache: misses, hits, eviction, flush, redirect, reset.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int n_chk  = 0;
    int n_pass = 0;
    int n_stall;

    inst_cache dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backing memory contents: line 0 holds 0x11..0x44, other words encode their address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0) return 32'h11 * (32'(a[3:2]) + 32'h1);
        return 32'hC000_0000 | a;
    endfunction

    // Drives one full miss from the detect cycle; inst_req/inst_addr already presented
    task automatic run_miss(input logic [31:0] a, input int ready_lo, input int d,
                            input int flush_beat, input logic [31:0] redir);
        logic [31:0] line;
        line    = {a[31:4], 4'h0};
        n_stall = 0;
        @(negedge clk);
        chk("det_valid", 32'(inst_valid), 32'h0);
        chk("det_inst", inst, 32'h0);
        chk("det_memreq", 32'(mem_req), 32'h0);
        if (stall) n_stall++;
        tick();
        for (int i = 0; i <= ready_lo; i++) begin
            mem_ready = (i == ready_lo);
            @(negedge clk);
            chk("req_memreq", 32'(mem_req), 32'h1);
            chk("req_addr", mem_addr, line);
            chk("req_stall", 32'(stall), 32'h1);
            if (stall) n_stall++;
            tick();
        end
        mem_ready = 1'b0;
        for (int i = 0; i < d - 1; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(line + 32'(4 * k));
            flush      = (k == flush_beat);
            if (k == 0 && redir != 32'h0) inst_addr = redir;
            @(negedge clk);
            chk("fill_memreq", 32'(mem_req), 32'h0);
            chk("fill_stall", 32'(stall), 32'h1);
            if (stall) n_stall++;
            tick();
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic exp_hit(input logic [31:0] a);
        inst_req  = 1'b1;
        inst_addr = a;
        @(negedge clk);
        chk("hit_valid", 32'(inst_valid), 32'h1);
        chk("hit_inst", inst, mem_word(a));
        chk("hit_stall", 32'(stall), 32'h0);
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        inst_req   = 1'b1;
        inst_addr  = 32'h0;
        flush      = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_memreq", 32'(mem_req), 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        tick();
        rst = 1'b0;

        // Cold miss: first beat in the first FILL cycle gives a 6-cycle stall
        run_miss(32'h0, 0, 1, -1, 32'h0);
        chk("cold_stall_cycles", 32'(n_stall), 32'd6);
        exp_hit(32'h0);
        exp_hit(32'h4);
        exp_hit(32'h8);
        exp_hit(32'hC);

        // Conflict eviction on index 0
        inst_addr = 32'h100;
        run_miss(32'h100, 0, 1, -1, 32'h0);
        exp_hit(32'h100);
        inst_addr = 32'h0;
        run_miss(32'h0, 0, 1, -1, 32'h0);
        exp_hit(32'h0);

        // Backpressure on the request, then flush in IDLE
        inst_addr = 32'h40;
        run_miss(32'h40, 5, 2, -1, 32'h0);
        exp_hit(32'h44);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(inst_valid), 32'h0);
        chk("flush_memreq", 32'(mem_req), 32'h0);
        tick();
        flush = 1'b0;
        run_miss(32'h40, 0, 1, -1, 32'h0);
        exp_hit(32'h40);

        // Flush during FILL: refill completes but the line stays invalid
        inst_addr = 32'h80;
        run_miss(32'h80, 0, 1, 1, 32'h0);
        run_miss(32'h80, 0, 1, -1, 32'h0);
        exp_hit(32'h8C);

        // Redirect mid-refill
        inst_addr = 32'h20;
        run_miss(32'h20, 0, 1, -1, 32'h300);
        run_miss(32'h300, 0, 1, -1, 32'h0);
        exp_hit(32'h300);
        exp_hit(32'h24);

        // No request: no stall, no memory traffic
        inst_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'h0);
            chk("idle_memreq", 32'(mem_req), 32'h0);
            tick();
        end

        // Reset mid-refill with trailing beats
        inst_req  = 1'b1;
        inst_addr = 32'hC0;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(32'hC0 + 32'(4 * k));
            tick();
        end
        rst       = 1'b1;
        inst_req  = 1'b0;
        mem_rdata = mem_word(32'hC8);
        @(negedge clk);
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_memreq", 32'(mem_req), 32'h0);
        tick();
        rst       = 1'b0;
        mem_rdata = mem_word(32'hCC);
        @(negedge clk);
        chk("postrst_stall", 32'(stall), 32'h0);
        chk("postrst_memreq", 32'(mem_req), 32'h0);
        tick();
        mem_rvalid = 1'b0;
        inst_req   = 1'b1;
        @(negedge clk);
        chk("postrst_miss_valid", 32'(inst_valid), 32'h0);
        chk("postrst_miss_stall", 32'(stall), 32'h1);
        tick();
        @(negedge clk);
        chk("postrst_memreq_up", 32'(mem_req), 32'h1);
        chk("postrst_memaddr", mem_addr, 32'hC0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
